// File: rtl/sa_os_feeder.sv
// Operand feeder for a 4x4 output-stationary systolic array: buffers one A/B tile,
// then streams it diagonally skewed while sequencing accumulator clear/enable.
module sa_os_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [4*DATA_WIDTH-1:0]      in_a_i,
    input  logic [4*DATA_WIDTH-1:0]      in_b_i,
    input  logic                         in_last_i,
    output logic signed [DATA_WIDTH-1:0] data_0_o,
    output logic signed [DATA_WIDTH-1:0] data_1_o,
    output logic signed [DATA_WIDTH-1:0] data_2_o,
    output logic signed [DATA_WIDTH-1:0] data_3_o,
    output logic signed [DATA_WIDTH-1:0] weight_0_o,
    output logic signed [DATA_WIDTH-1:0] weight_1_o,
    output logic signed [DATA_WIDTH-1:0] weight_2_o,
    output logic signed [DATA_WIDTH-1:0] weight_3_o,
    output logic                         acc_en_o,
    output logic                         acc_clr_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         trunc_o
);
    localparam int PW = $clog2(DEPTH + 7);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_LOAD, S_CLEAR, S_STREAM, S_DONE} state_e;

    state_e                          state_q;
    logic [PW-1:0]                   wr_ptr_q, k_q, t_q;
    logic [4*DATA_WIDTH-1:0]         a_buf [DEPTH];
    logic [4*DATA_WIDTH-1:0]         b_buf [DEPTH];
    logic [3:0][DATA_WIDTH-1:0]      data_q, weight_q, data_d, weight_d;
    logic                            acc_en_q, acc_clr_q, done_q;
    logic                            accept, at_end;
    logic [PW-1:0]                   step_d;
    logic [3:0][PW-1:0]              idx;
    logic [3:0]                      hit;

    assign accept     = in_valid_i && (state_q == S_LOAD);
    assign at_end     = (wr_ptr_q == PW'(DEPTH - 1));
    assign in_ready_o = rstn && (state_q == S_LOAD);
    assign trunc_o    = in_ready_o && in_valid_i && at_end && !in_last_i;
    assign busy_o     = (state_q != S_LOAD);
    assign acc_en_o   = acc_en_q;
    assign acc_clr_o  = acc_clr_q;
    assign done_o     = done_q;

    assign data_0_o   = data_q[0];
    assign data_1_o   = data_q[1];
    assign data_2_o   = data_q[2];
    assign data_3_o   = data_q[3];
    assign weight_0_o = weight_q[0];
    assign weight_1_o = weight_q[1];
    assign weight_2_o = weight_q[2];
    assign weight_3_o = weight_q[3];

    always_ff @(posedge clk) begin
        if (accept) begin
            a_buf[wr_ptr_q[AW-1:0]] <= in_a_i;
            b_buf[wr_ptr_q[AW-1:0]] <= in_b_i;
        end
    end

    // Lane values for the step about to be displayed: lane i lags the step counter by i.
    always_comb begin
        step_d   = (state_q == S_STREAM) ? t_q + PW'(1) : '0;
        idx      = '0;
        hit      = '0;
        data_d   = '0;
        weight_d = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx[i] = step_d - PW'(i);
            hit[i] = (step_d >= PW'(i)) && (idx[i] < k_q);
            if (hit[i]) begin
                data_d[i]   = a_buf[idx[i][AW-1:0]][i*DATA_WIDTH +: DATA_WIDTH];
                weight_d[i] = b_buf[idx[i][AW-1:0]][i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_LOAD;
            wr_ptr_q  <= '0;
            k_q       <= '0;
            t_q       <= '0;
            data_q    <= '0;
            weight_q  <= '0;
            acc_en_q  <= 1'b0;
            acc_clr_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            acc_clr_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_LOAD: begin
                    if (accept) begin
                        if (in_last_i || at_end) begin
                            k_q       <= wr_ptr_q + PW'(1);
                            wr_ptr_q  <= '0;
                            acc_clr_q <= 1'b1;
                            data_q    <= '0;
                            weight_q  <= '0;
                            state_q   <= S_CLEAR;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + PW'(1);
                        end
                    end
                end
                S_CLEAR: begin
                    t_q      <= '0;
                    acc_en_q <= 1'b1;
                    data_q   <= data_d;
                    weight_q <= weight_d;
                    state_q  <= S_STREAM;
                end
                S_STREAM: begin
                    if (t_q == k_q + PW'(5)) begin
                        t_q      <= '0;
                        acc_en_q <= 1'b0;
                        done_q   <= 1'b1;
                        data_q   <= '0;
                        weight_q <= '0;
                        state_q  <= S_DONE;
                    end else begin
                        t_q      <= t_q + PW'(1);
                        data_q   <= data_d;
                        weight_q <= weight_d;
                    end
                end
                S_DONE:  state_q <= S_LOAD;
                default: state_q <= S_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_sa_os_feeder.sv
// Directed bench for sa_os_feeder: checks lane skew, sequencing, truncation, reset abort,
// and the C=A*B result of an ideal 4x4 output-stationary array fed by the lanes.
module tb_sa_os_feeder;
    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 in_valid_i, in_last_i;
    logic [4*DW-1:0]      in_a_i, in_b_i;
    logic                 in_ready_o, acc_en_o, acc_clr_o, busy_o, done_o, trunc_o;
    logic signed [DW-1:0] dq [4];
    logic signed [DW-1:0] wq [4];

    int total = 0;
    int bad   = 0;
    int clr_seen;

    logic signed [DW-1:0] ta  [4][DEPTH];
    logic signed [DW-1:0] tbm [DEPTH][4];
    logic signed [DW-1:0] dh  [4][32];
    logic signed [DW-1:0] wh  [4][32];
    longint               cm  [4][4];

    sa_os_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_a_i(in_a_i), .in_b_i(in_b_i), .in_last_i(in_last_i),
        .data_0_o(dq[0]), .data_1_o(dq[1]), .data_2_o(dq[2]), .data_3_o(dq[3]),
        .weight_0_o(wq[0]), .weight_1_o(wq[1]), .weight_2_o(wq[2]), .weight_3_o(wq[3]),
        .acc_en_o(acc_en_o), .acc_clr_o(acc_clr_o), .busy_o(busy_o),
        .done_o(done_o), .trunc_o(trunc_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] z(input logic [DW-1:0] v);
        return {48'b0, v};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_lanes(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_d%0d", tag, i), z(dq[i]), 64'd0);
            check($sformatf("%s_w%0d", tag, i), z(wq[i]), 64'd0);
        end
    endtask

    // Called at posedge+1; beat is accepted at the next posedge.
    task automatic send_beat(input int k, input bit last, input bit exp_trunc);
        in_valid_i = 1'b1;
        in_last_i  = last;
        for (int i = 0; i < 4; i++) begin
            in_a_i[i*DW +: DW] = ta[i][k];
            in_b_i[i*DW +: DW] = tbm[k][i];
        end
        #1;
        check($sformatf("ready_b%0d", k), in_ready_o, 64'd1);
        check($sformatf("trunc_b%0d", k), trunc_o, exp_trunc);
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic load_tile(input int k, input bit use_last, input bit gaps);
        for (int b = 0; b < k; b++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_a_i = {$urandom, $urandom};
                    in_b_i = {$urandom, $urandom};
                    @(posedge clk); #1;
                end
            end
            send_beat(b, use_last && (b == k - 1), (b == DEPTH - 1) && !(use_last && (b == k - 1)));
        end
    endtask

    task automatic noisy_inputs();
        in_valid_i = 1'b1;
        in_last_i  = 1'($urandom);
        in_a_i     = {$urandom, $urandom};
        in_b_i     = {$urandom, $urandom};
    endtask

    // Entered at posedge+1 right after the final beat, i.e. during the CLEAR cycle.
    task automatic run_tile(input int k, input bit noise);
        longint acc, rf;
        clr_seen = 0;
        if (noise) noisy_inputs();
        check("clr_pulse", acc_clr_o, 64'd1);
        check("clr_acc_en", acc_en_o, 64'd0);
        check("clr_busy", busy_o, 64'd1);
        check("clr_ready", in_ready_o, 64'd0);
        check_idle_lanes("clr");
        clr_seen += int'(acc_clr_o);
        for (int t = 0; t < k + 6; t++) begin
            @(posedge clk); #1;
            if (noise) noisy_inputs();
            check($sformatf("st_acc_en_t%0d", t), acc_en_o, 64'd1);
            check($sformatf("st_done_t%0d", t), done_o, 64'd0);
            check($sformatf("st_ready_t%0d", t), in_ready_o, 64'd0);
            for (int i = 0; i < 4; i++) begin
                logic [DW-1:0] ed, ew;
                ed = (t >= i && t - i < k) ? ta[i][t-i]  : '0;
                ew = (t >= i && t - i < k) ? tbm[t-i][i] : '0;
                check($sformatf("data%0d_t%0d", i, t), z(dq[i]), z(ed));
                check($sformatf("weight%0d_t%0d", i, t), z(wq[i]), z(ew));
                dh[i][t] = dq[i];
                wh[i][t] = wq[i];
            end
            clr_seen += int'(acc_clr_o);
        end
        @(posedge clk); #1;
        check("done_pulse", done_o, 64'd1);
        check("done_acc_en", acc_en_o, 64'd0);
        check("done_busy", busy_o, 64'd1);
        check_idle_lanes("done");
        clr_seen += int'(acc_clr_o);
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        check("post_done", done_o, 64'd0);
        check("post_busy", busy_o, 64'd0);
        check("post_ready", in_ready_o, 64'd1);
        clr_seen += int'(acc_clr_o);
        check("clr_once", clr_seen, 64'd1);
        // Ideal array: PE(i,j) sees data_i delayed j and weight_j delayed i.
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = 0;
                rf  = 0;
                for (int t = 0; t < k + 6; t++)
                    if (t >= i && t >= j) acc += longint'(dh[i][t-j]) * longint'(wh[j][t-i]);
                for (int kk = 0; kk < k; kk++) rf += longint'(ta[i][kk]) * longint'(tbm[kk][j]);
                cm[i][j] = acc;
                check($sformatf("C%0d%0d", i, j), acc, rf);
            end
        end
    endtask

    initial begin
        rstn       = 1'b0;
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        in_a_i     = '0;
        in_b_i     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", in_ready_o, 64'd0);
        check("rst_busy", busy_o, 64'd0);
        check("rst_acc_en", acc_en_o, 64'd0);
        check("rst_acc_clr", acc_clr_o, 64'd0);
        check("rst_done", done_o, 64'd0);
        check("rst_trunc", trunc_o, 64'd0);
        check_idle_lanes("rst");
        #2 rstn = 1'b1;
        @(posedge clk); #1;
        check("rel_ready", in_ready_o, 64'd1);

        // Identity A, B[k][j] = 4k+j+1; C must equal B
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ta[i][k]  = (i == k) ? 16'sd1 : 16'sd0;
                tbm[k][i] = DW'(4 * k + i + 1);
            end
        load_tile(4, 1'b1, 1'b0);
        run_tile(4, 1'b0);
        check("id_C23", cm[2][3], 64'd12);

        // Skew: A[i][k]=10i+k, B[k][j]=100k+j, K=2; third STREAM cycle (t=2)
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 2; k++) begin
                ta[i][k]  = DW'(10 * i + k);
                tbm[k][i] = DW'(100 * k + i);
            end
        load_tile(2, 1'b1, 1'b0);
        run_tile(2, 1'b0);
        check("skew_d0", z(dh[0][2]), 64'd0);
        check("skew_d1", z(dh[1][2]), 64'd11);
        check("skew_d2", z(dh[2][2]), 64'd20);
        check("skew_d3", z(dh[3][2]), 64'd0);
        check("skew_w1", z(wh[1][2]), 64'd101);
        check("skew_w3", z(wh[3][2]), 64'd0);

        // Signed extremes, K=1
        for (int i = 0; i < 4; i++) begin
            ta[i][0]  = 16'sh8000;
            tbm[0][i] = 16'sh8000;
        end
        load_tile(1, 1'b1, 1'b0);
        run_tile(1, 1'b0);
        check("ext_d0", z(dh[0][0]), 64'h8000);
        check("ext_w3", z(wh[3][3]), 64'h8000);
        check("ext_C00", cm[0][0], 64'd1073741824);

        // Overflow: 16 beats, no in_last; trunc on the 16th accept
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < DEPTH; k++) begin
                ta[i][k]  = DW'($urandom);
                tbm[k][i] = DW'($urandom);
            end
        load_tile(DEPTH, 1'b0, 1'b0);
        run_tile(DEPTH, 1'b0);

        // Gaps in LOAD and noise on the load port while busy
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 5; k++) begin
                ta[i][k]  = DW'($urandom_range(0, 2000)) - 16'sd1000;
                tbm[k][i] = DW'($urandom_range(0, 2000)) - 16'sd1000;
            end
        load_tile(5, 1'b1, 1'b1);
        run_tile(5, 1'b1);

        // Reset during STREAM t=3, then a fresh K=4 tile
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ta[i][k]  = DW'(i + 2 * k + 1);
                tbm[k][i] = DW'(3 * k - i);
            end
        load_tile(4, 1'b1, 1'b0);
        for (int t = 0; t < 4; t++) begin
            @(posedge clk); #1;
        end
        check("abort_pre_acc_en", acc_en_o, 64'd1);
        check("abort_pre_d2", z(dq[2]), z(ta[2][1]));
        rstn = 1'b0;
        #1;
        check("abort_acc_en", acc_en_o, 64'd0);
        check("abort_busy", busy_o, 64'd0);
        check("abort_ready", in_ready_o, 64'd0);
        check("abort_done", done_o, 64'd0);
        check_idle_lanes("abort");
        #2 rstn = 1'b1;
        #1;
        check("abort_rel_ready", in_ready_o, 64'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ta[i][k]  = DW'(5 * i - k);
                tbm[k][i] = DW'(k * i + 7);
            end
        load_tile(4, 1'b1, 1'b0);
        run_tile(4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
